// File: rtl/xconf_mem_pkg.sv
// xconf_mem_pkg: address map, defaults and FSM states for the configuration memory
package xconf_mem_pkg;
  localparam int CONF_BITS_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int CONF_REG_ADDR_W = 4;
  localparam int ADDR_W = CONF_REG_ADDR_W + 1;
  localparam int CONF_MEM_SLOTS = 64;
  localparam logic [ADDR_W-1:0] CONF_MEM_SAVE = 5'h10;
  localparam logic [ADDR_W-1:0] CONF_MEM_LOAD = 5'h11;
  localparam logic [ADDR_W-1:0] CONF_MEM_STATUS = 5'h12;
  typedef enum logic [1:0] {IDLE, SAVE, RD, LD} state_t;
endpackage

// File: rtl/xconf_mem_if.sv
// xconf_mem_if: req/rnw/addr/data control bus shared with the configuration register
interface xconf_mem_if #(
  parameter int DATA_W = xconf_mem_pkg::DATA_W_DEF,
  parameter int ADDR_W = xconf_mem_pkg::ADDR_W
);
  logic req;
  logic rnw;
  logic busy;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  modport master(output req, rnw, addr, data_in, input data_out, busy);
  modport slave(input req, rnw, addr, data_in, output data_out, busy);
endinterface

// File: rtl/xconf_mem_ram.sv
// xconf_mem_ram: single-port synchronous RAM with registered read, no reset
module xconf_mem_ram #(
  parameter int W = 32,
  parameter int D = 64,
  parameter int AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [D];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/xconf_mem.sv
// xconf_mem: saves/restores whole datapath configurations to/from a slot RAM
module xconf_mem import xconf_mem_pkg::*; #(
  parameter int CONF_BITS = CONF_BITS_DEF,
  parameter int SLOTS = CONF_MEM_SLOTS,
  parameter int SLOT_W = $clog2(SLOTS),
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CONF_BITS-1:0] conf_cur,
  output logic [CONF_BITS-1:0] conf_in,
  output logic                 conf_ld,
  xconf_mem_if.slave           ctl
);
  state_t state, state_nx;
  logic [SLOT_W-1:0] last_slot, slot;
  logic [CONF_BITS-1:0] rdata;
  logic ovf, busy, wr, save_cmd, load_cmd, cmd, st_rd, unused_data;
  assign slot = ctl.data_in[SLOT_W-1:0];
  assign unused_data = ^ctl.data_in[DATA_W-1:SLOT_W];
  assign wr = ctl.req & ~ctl.rnw;
  assign save_cmd = wr & (ctl.addr == CONF_MEM_SAVE);
  assign load_cmd = wr & (ctl.addr == CONF_MEM_LOAD);
  assign cmd = save_cmd | load_cmd;
  assign st_rd = ctl.req & ctl.rnw & (ctl.addr == CONF_MEM_STATUS);
  assign busy = state != IDLE;
  assign ctl.busy = busy;
  always_comb begin
    state_nx = IDLE;
    if (state == IDLE) state_nx = save_cmd ? SAVE : load_cmd ? RD : IDLE;
    else if (state == RD) state_nx = LD;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // a drop wins over a same-cycle status read so the overflow is never lost
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      last_slot <= '0;
      ovf <= 1'b0;
      conf_ld <= 1'b0;
      conf_in <= '0;
      ctl.data_out <= '0;
    end else begin
      if (cmd && !busy) last_slot <= slot;
      ovf <= (cmd & busy) | (ovf & ~st_rd);
      conf_ld <= state == LD;
      if (state == LD) conf_in <= rdata;
      if (ctl.req && ctl.rnw) ctl.data_out <= st_rd ? DATA_W'({ovf, busy, last_slot}) : '0;
    end
  xconf_mem_ram #(.W(CONF_BITS), .D(SLOTS), .AW(SLOT_W)) u_ram (
    .clk(clk),
    .we(state == SAVE),
    .addr(last_slot),
    .wdata(conf_cur),
    .rdata(rdata)
  );
endmodule
